// File: rtl/poke_pkg.sv
// poke_pkg: button indices, direction and auto-repeat state types shared by the conditioner
package poke_pkg;
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_SEL   = 4;
    localparam int NUM_BTN   = 5;

    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
    typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} rpt_state_t;

    function automatic dir_t lowest_dir(input logic [3:0] v);
        return v[BTN_UP] ? DIR_UP : v[BTN_DOWN] ? DIR_DOWN : v[BTN_LEFT] ? DIR_LEFT : DIR_RIGHT;
    endfunction
endpackage

// File: rtl/button_debounce.sv
// button_debounce: synchronises one raw button, debounces it and flags the cycle its level rises
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 650000,
    parameter int CW              = 21
) (
    input  logic vclk_in,
    input  logic rst_n_in,
    input  logic raw_in,
    output logic level_out,
    output logic rise_out
);
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d, rise_q, hit;

    assign hit = cnt_q == CW'(DEBOUNCE_CYCLES - 1);

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            level_d = hit ? ~level_q : level_q;
            cnt_d   = hit ? '0 : cnt_q + CW'(!(&cnt_q));
        end
    end

    always_ff @(posedge vclk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw_in};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= level_d & ~level_q;
        end
    end

    assign level_out = level_q;
    assign rise_out  = rise_q;
endmodule

// File: rtl/poke_button_conditioner.sv
// poke_button_conditioner: debounced button levels, press/auto-repeat pulses, per-frame press flags
// and a last-pressed-wins walking direction
module poke_button_conditioner
    import poke_pkg::*;
#(
    parameter int                 DEBOUNCE_CYCLES = 650000,
    parameter int                 REPEAT_DELAY    = 19500000,
    parameter int                 REPEAT_PERIOD   = 6500000,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 5'b01111
) (
    input  logic               vclk_in,
    input  logic               rst_n_in,
    input  logic [NUM_BTN-1:0] btn_raw_in,
    input  logic               vsync_in,
    output logic [NUM_BTN-1:0] btn_level_out,
    output logic [NUM_BTN-1:0] btn_press_out,
    output logic [NUM_BTN-1:0] btn_frame_out,
    output logic               dir_valid_out,
    output logic [1:0]         dir_out
);
    localparam int MAX_CYC = DEBOUNCE_CYCLES > REPEAT_DELAY
        ? (DEBOUNCE_CYCLES > REPEAT_PERIOD ? DEBOUNCE_CYCLES : REPEAT_PERIOD)
        : (REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam int CW = $clog2(MAX_CYC) + 1;

    logic [NUM_BTN-1:0] level, rise, press_d, press_q, frame_q;
    logic [3:0]         held, pulses;
    logic               vs_q, frame_edge;
    dir_t               dir_q, dir_d;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CW(CW)) u_debounce (
            .vclk_in  (vclk_in),
            .rst_n_in (rst_n_in),
            .raw_in   (btn_raw_in[i]),
            .level_out(level[i]),
            .rise_out (rise[i])
        );
        if (REPEAT_MASK[i]) begin : g_rpt
            rpt_state_t    st_q, st_d;
            logic [CW-1:0] cnt_q, cnt_d;
            logic          due;
            // a falling level is checked first so it always beats a repeat that is due
            always_comb begin
                st_d  = st_q;
                cnt_d = '0;
                due   = 1'b0;
                if (!level[i])
                    st_d = RPT_IDLE;
                else if (st_q == RPT_IDLE)
                    st_d = rise[i] ? RPT_DELAY : RPT_IDLE;
                else begin
                    due   = cnt_q == (st_q == RPT_DELAY ? CW'(REPEAT_DELAY - 1) : CW'(REPEAT_PERIOD - 1));
                    st_d  = due ? RPT_REPEAT : st_q;
                    cnt_d = due ? '0 : cnt_q + CW'(!(&cnt_q));
                end
            end
            always_ff @(posedge vclk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    st_q  <= RPT_IDLE;
                    cnt_q <= '0;
                end else begin
                    st_q  <= st_d;
                    cnt_q <= cnt_d;
                end
            end
            assign press_d[i] = rise[i] | due;
        end else begin : g_norpt
            assign press_d[i] = rise[i];
        end
    end

    assign frame_edge = vs_q & ~vsync_in;
    assign held       = level[BTN_RIGHT:BTN_UP];
    assign pulses     = press_q[BTN_RIGHT:BTN_UP];
    // fresh pulses win; otherwise fall back to a still-held direction once ours is released
    assign dir_d = |pulses ? lowest_dir(pulses)
                 : (!held[dir_q] && |held) ? lowest_dir(held) : dir_q;

    always_ff @(posedge vclk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            press_q <= '0;
            frame_q <= '0;
            vs_q    <= 1'b0;
            dir_q   <= DIR_UP;
        end else begin
            press_q <= press_d;
            frame_q <= (frame_edge ? '0 : frame_q) | press_q;
            vs_q    <= vsync_in;
            dir_q   <= dir_d;
        end
    end

    assign btn_level_out = level;
    assign btn_press_out = press_q;
    assign btn_frame_out = frame_q;
    assign dir_valid_out = |held;
    assign dir_out       = dir_q;
endmodule

// File: tb/tb_poke_button_conditioner.sv
// tb_poke_button_conditioner: directed stimulus, press pulses checked by a cycle-stamped scoreboard
module tb_poke_button_conditioner;
    typedef struct {
        int         cyc;
        logic [4:0] mask;
    } ev_t;

    logic       clk = 1'b0, rst_n = 1'b0, vsync = 1'b1;
    logic [4:0] raw = '0;
    logic [4:0] level, press, frame;
    logic       dir_valid;
    logic [1:0] dir;
    int         cyc = 0, total = 0, bad = 0;
    ev_t        q[$];

    poke_button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) dut (
        .vclk_in      (clk),
        .rst_n_in     (rst_n),
        .btn_raw_in   (raw),
        .vsync_in     (vsync),
        .btn_level_out(level),
        .btn_press_out(press),
        .btn_frame_out(frame),
        .dir_valid_out(dir_valid),
        .dir_out      (dir)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic expect_press(input int c, input logic [4:0] m);
        q.push_back('{c, m});
    endtask

    task automatic go_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic monitor();
        ev_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL press_missed: got no pulse at cycle %0d, expected mask %b", q[0].cyc, q[0].mask);
                void'(q.pop_front());
            end
            if (rst_n && press != 5'b0) begin
                total++;
                if (q.size() == 0 || q[0].cyc != cyc) begin
                    bad++;
                    $display("FAIL press_unexpected: got mask %b at cycle %0d, expected no pulse", press, cyc);
                end else begin
                    e = q.pop_front();
                    if (e.mask != press) begin
                        bad++;
                        $display("FAIL press_mask at cycle %0d: got %b, expected %b", cyc, press, e.mask);
                    end
                end
            end
        end
    endtask

    initial begin
        int t, cf, tu, r;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        check("rst_level", 32'(level), 0);
        check("rst_press", 32'(press), 0);
        check("rst_frame", 32'(frame), 0);
        check("rst_dir_valid", 32'(dir_valid), 0);
        check("rst_dir", 32'(dir), 0);
        rst_n = 1'b1;
        go_to(cyc + 3);

        // bouncing up button: only the final edge is debounced
        t = cyc;
        for (int i = 0; i < 7; i++) begin
            raw[0] = ~raw[0];
            go_to(t + 2 * i + 2);
        end
        cf = t + 12;
        expect_press(cf + 7, 5'b00001);
        go_to(cf + 5);
        check("bounce_level_early", 32'(level[0]), 0);
        go_to(cf + 6);
        check("bounce_level_rise", 32'(level[0]), 1);
        go_to(cf + 10);
        raw[0] = 1'b0;
        go_to(cf + 16);
        check("bounce_level_fall", 32'(level[0]), 0);
        go_to(cf + 20);

        // left held: initial pulse then repeats at +20, +28, ...
        t = cyc;
        raw[2] = 1'b1;
        for (int k = 0; k < 6; k++) expect_press(t + 7 + (k == 0 ? 0 : 12 + 8 * k), 5'b00100);
        go_to(t + 57);
        raw[2] = 1'b0;
        go_to(t + 77);

        // left released so the level falls on the very cycle a repeat is due
        t = cyc;
        raw[2] = 1'b1;
        for (int k = 0; k < 5; k++) expect_press(t + 7 + (k == 0 ? 0 : 12 + 8 * k), 5'b00100);
        go_to(t + 52);
        raw[2] = 1'b0;
        go_to(t + 57);
        check("rpt_level_held", 32'(level[2]), 1);
        go_to(t + 58);
        check("rpt_level_fall", 32'(level[2]), 0);
        go_to(t + 80);

        // sel never repeats
        t = cyc;
        raw[4] = 1'b1;
        expect_press(t + 7, 5'b10000);
        go_to(t + 30);
        check("sel_level", 32'(level[4]), 1);
        go_to(t + 67);
        raw[4] = 1'b0;
        go_to(t + 80);

        // frame boundary with no press clears every flag
        t = cyc;
        vsync = 1'b0;
        go_to(t + 2);
        check("frame_clear", 32'(frame), 0);
        go_to(t + 3);
        vsync = 1'b1;

        // down pressed mid-frame
        t = cyc;
        raw[1] = 1'b1;
        expect_press(t + 7, 5'b00010);
        go_to(t + 10);
        raw[1] = 1'b0;
        go_to(t + 12);
        check("frame_mid_set", 32'(frame[1]), 1);
        go_to(t + 20);
        vsync = 1'b0;
        check("frame_mid_hold", 32'(frame[1]), 1);
        go_to(t + 21);
        check("frame_mid_clear", 32'(frame[1]), 0);
        go_to(t + 23);
        vsync = 1'b1;

        // down press landing exactly on the boundary cycle belongs to the new frame
        go_to(cyc + 5);
        t = cyc;
        raw[1] = 1'b1;
        expect_press(t + 7, 5'b00010);
        go_to(t + 7);
        vsync = 1'b0;
        go_to(t + 8);
        check("frame_edge_set", 32'(frame[1]), 1);
        go_to(t + 10);
        raw[1] = 1'b0;
        vsync = 1'b1;
        go_to(t + 40);
        check("frame_edge_hold", 32'(frame[1]), 1);
        vsync = 1'b0;
        go_to(t + 41);
        check("frame_edge_clear", 32'(frame[1]), 0);
        go_to(t + 43);
        vsync = 1'b1;

        // up held, right pressed, right released, up released
        go_to(cyc + 5);
        t = cyc;
        raw[0] = 1'b1;
        tu = t + 7;
        expect_press(tu, 5'b00001);
        go_to(tu + 1);
        raw[3] = 1'b1;
        expect_press(tu + 8, 5'b01000);
        go_to(tu + 2);
        check("dir_up", 32'(dir), 0);
        check("dir_valid_up", 32'(dir_valid), 1);
        go_to(tu + 10);
        check("dir_right", 32'(dir), 3);
        go_to(tu + 11);
        raw[3] = 1'b0;
        go_to(tu + 19);
        check("dir_fallback_up", 32'(dir), 0);
        raw[0] = 1'b0;
        expect_press(tu + 20, 5'b00001);
        go_to(tu + 30);
        check("dir_valid_none", 32'(dir_valid), 0);
        check("dir_hold_up", 32'(dir), 0);

        // simultaneous down+right: down wins, then fallback to right, then hold when released
        go_to(cyc + 5);
        t = cyc;
        raw[1] = 1'b1;
        raw[3] = 1'b1;
        expect_press(t + 7, 5'b01010);
        go_to(t + 9);
        check("dir_priority", 32'(dir), 1);
        go_to(t + 10);
        raw[1] = 1'b0;
        go_to(t + 18);
        check("dir_fallback_right", 32'(dir), 3);
        raw[3] = 1'b0;
        go_to(t + 30);
        check("dir_valid_off", 32'(dir_valid), 0);
        check("dir_hold_right", 32'(dir), 3);

        // reset in the middle of the repeat delay with left held
        go_to(cyc + 5);
        t = cyc;
        raw[2] = 1'b1;
        expect_press(t + 7, 5'b00100);
        go_to(t + 12);
        rst_n = 1'b0;
        #1;
        check("midrst_level", 32'(level), 0);
        check("midrst_press", 32'(press), 0);
        check("midrst_frame", 32'(frame), 0);
        check("midrst_dir_valid", 32'(dir_valid), 0);
        check("midrst_dir", 32'(dir), 0);
        go_to(t + 15);
        rst_n = 1'b1;
        r = t + 15;
        expect_press(r + 7, 5'b00100);
        go_to(r + 5);
        check("postrst_level_early", 32'(level[2]), 0);
        go_to(r + 6);
        check("postrst_level_rise", 32'(level[2]), 1);
        go_to(r + 10);
        raw[2] = 1'b0;
        go_to(r + 40);

        check("queue_empty", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish by cycle %0d, expected finish before 5000", cyc);
        $fatal(1, "timeout");
    end
endmodule
